pipe_hazard_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the 5-stage pipeline (IF/ID/EX/MEM/WB). It keeps its own shadow scoreboard of the ID/EX, EX/MEM and MEM/WB destination/control state. From that scoreboard it generates the following:
- PC and IF/ID enables
- IF/ID and ID/EX flushes
- EX-operand forwarding selects
- ID-stage write-back bypass selects
- saturating stall/flush performance counters

It supports full forwarding or pure interlock operation, and handles taken-branch redirects.

---
 rtl/pipe_pkg.sv | 35 +++
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types, forwarding-select encodings and helpers for the pipeline hazard controller.
package pipe_pkg;

  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] rd;
    logic [REG_AW_DEF-1:0] rs1;
    logic [REG_AW_DEF-1:0] rs2;
    logic                  regwrite;
    logic                  memread;
  } slot_t;

  // MEM and WB only ever act as producers, so they keep just the write port.
  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] rd;
    logic                  regwrite;
  } wr_t;

  localparam slot_t SLOT_BUBBLE = '0;
  localparam wr_t   WR_BUBBLE   = '0;

  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
    if (mem_hit) return FWD_EXMEM;
    if (wb_hit)  return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for a 5-stage pipeline: shadow scoreboard of EX/MEM/WB producers,
// PC/IF-ID enables, flushes, EX forwarding selects, ID write-back bypass and event counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_regwrite,
  input  logic              i_id_memread,
  input  logic              i_ex_branch_taken,
  output logic              o_pc_en,
  output logic              o_ifid_en,
  output logic              o_ifid_flush,
  output logic              o_idex_flush,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b,
  output logic              o_id_byp_a,
  output logic              o_id_byp_b,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  // Addresses are held at the package width; REG_AW must not exceed REG_AW_DEF.
  typedef logic [REG_AW_DEF-1:0] addr_t;

  function automatic logic hit(input logic wr, input addr_t rd, input addr_t src);
    return wr && (rd == src);
  endfunction

  slot_t r_ex;
  wr_t   r_mem;
  wr_t   r_wb;

  slot_t w_id_slot;
  addr_t w_src1;
  addr_t w_src2;
  logic  w_ex_wr;
  logic  w_mem_wr;
  logic  w_wb_wr;
  logic  w_id_ex_hit;
  logic  w_id_mem_hit;
  logic  w_hazard;
  logic  w_stall;
  logic  w_flush;

  // Unread sources collapse to x0, which can never match an effective write.
  assign w_src1 = i_id_use_rs1 ? addr_t'(i_id_rs1) : '0;
  assign w_src2 = i_id_use_rs2 ? addr_t'(i_id_rs2) : '0;

  assign w_id_slot = '{valid:    i_id_valid,
                       rd:       addr_t'(i_id_rd),
                       rs1:      w_src1,
                       rs2:      w_src2,
                       regwrite: i_id_regwrite,
                       memread:  i_id_memread};

  assign w_ex_wr  = r_ex.valid  & r_ex.regwrite  & (r_ex.rd  != '0);
  assign w_mem_wr = r_mem.valid & r_mem.regwrite & (r_mem.rd != '0);
  assign w_wb_wr  = r_wb.valid  & r_wb.regwrite  & (r_wb.rd  != '0);

  assign w_id_ex_hit  = hit(w_ex_wr, r_ex.rd, w_src1)   | hit(w_ex_wr, r_ex.rd, w_src2);
  assign w_id_mem_hit = hit(w_mem_wr, r_mem.rd, w_src1) | hit(w_mem_wr, r_mem.rd, w_src2);

  assign w_hazard = FWD_EN ? (w_id_ex_hit & r_ex.memread) : (w_id_ex_hit | w_id_mem_hit);
  assign w_flush  = ~i_reset & i_ex_branch_taken;
  assign w_stall  = ~i_reset & ~i_ex_branch_taken & i_id_valid & w_hazard;

  // A taken branch outranks a stall: the ID instruction is squashed anyway.
  always_comb begin
    o_pc_en      = 1'b1;
    o_ifid_en    = 1'b1;
    o_ifid_flush = 1'b0;
    o_idex_flush = 1'b0;
    if (i_reset) begin
      o_pc_en      = 1'b0;
      o_ifid_en    = 1'b0;
      o_ifid_flush = 1'b1;
      o_idex_flush = 1'b1;
    end else if (w_flush) begin
      o_ifid_flush = 1'b1;
      o_idex_flush = 1'b1;
    end else if (w_stall) begin
      o_pc_en      = 1'b0;
      o_ifid_en    = 1'b0;
      o_idex_flush = 1'b1;
    end
  end

  assign o_fwd_a = (FWD_EN && !i_reset)
                 ? fwd_sel(hit(w_mem_wr, r_mem.rd, r_ex.rs1), hit(w_wb_wr, r_wb.rd, r_ex.rs1))
                 : FWD_RF;
  assign o_fwd_b = (FWD_EN && !i_reset)
                 ? fwd_sel(hit(w_mem_wr, r_mem.rd, r_ex.rs2), hit(w_wb_wr, r_wb.rd, r_ex.rs2))
                 : FWD_RF;

  assign o_id_byp_a = ~i_reset & hit(w_wb_wr, r_wb.rd, w_src1);
  assign o_id_byp_b = ~i_reset & hit(w_wb_wr, r_wb.rd, w_src2);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ex  <= SLOT_BUBBLE;
      r_mem <= WR_BUBBLE;
      r_wb  <= WR_BUBBLE;
    end else begin
      r_ex  <= o_idex_flush ? SLOT_BUBBLE : w_id_slot;
      r_mem <= '{valid: r_ex.valid, rd: r_ex.rd, regwrite: r_ex.regwrite};
      r_wb  <= r_mem;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk (i_clk),
    .i_clr (i_reset),
    .i_inc (w_stall),
    .o_cnt (o_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .i_clk (i_clk),
    .i_clr (i_reset),
    .i_inc (w_flush),
    .o_cnt (o_flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: forwarding, interlock and 2-bit-counter instances share one
// instruction stream and are checked each cycle against a per-instance pipeline model.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, rw, mr, br;

  logic       pc_en [3];
  logic       ifid_en [3];
  logic       ifid_flush [3];
  logic       idex_flush [3];
  logic [1:0] fwd_a [3];
  logic [1:0] fwd_b [3];
  logic       byp_a [3];
  logic       byp_b [3];
  logic [15:0] scnt_f, scnt_i, fcnt_f, fcnt_i;
  logic [1:0]  scnt_s, fcnt_s;

  int checks = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b1), .CNT_W(16)) u_fwd (
    .i_clk(clk), .i_reset(rst), .i_id_valid(id_valid), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_use_rs1(u1), .i_id_use_rs2(u2), .i_id_rd(rd), .i_id_regwrite(rw),
    .i_id_memread(mr), .i_ex_branch_taken(br), .o_pc_en(pc_en[0]), .o_ifid_en(ifid_en[0]),
    .o_ifid_flush(ifid_flush[0]), .o_idex_flush(idex_flush[0]), .o_fwd_a(fwd_a[0]),
    .o_fwd_b(fwd_b[0]), .o_id_byp_a(byp_a[0]), .o_id_byp_b(byp_b[0]),
    .o_stall_cnt(scnt_f), .o_flush_cnt(fcnt_f));

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b0), .CNT_W(16)) u_ilk (
    .i_clk(clk), .i_reset(rst), .i_id_valid(id_valid), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_use_rs1(u1), .i_id_use_rs2(u2), .i_id_rd(rd), .i_id_regwrite(rw),
    .i_id_memread(mr), .i_ex_branch_taken(br), .o_pc_en(pc_en[1]), .o_ifid_en(ifid_en[1]),
    .o_ifid_flush(ifid_flush[1]), .o_idex_flush(idex_flush[1]), .o_fwd_a(fwd_a[1]),
    .o_fwd_b(fwd_b[1]), .o_id_byp_a(byp_a[1]), .o_id_byp_b(byp_b[1]),
    .o_stall_cnt(scnt_i), .o_flush_cnt(fcnt_i));

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b1), .CNT_W(2)) u_sat (
    .i_clk(clk), .i_reset(rst), .i_id_valid(id_valid), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_use_rs1(u1), .i_id_use_rs2(u2), .i_id_rd(rd), .i_id_regwrite(rw),
    .i_id_memread(mr), .i_ex_branch_taken(br), .o_pc_en(pc_en[2]), .o_ifid_en(ifid_en[2]),
    .o_ifid_flush(ifid_flush[2]), .o_idex_flush(idex_flush[2]), .o_fwd_a(fwd_a[2]),
    .o_fwd_b(fwd_b[2]), .o_id_byp_a(byp_a[2]), .o_id_byp_b(byp_b[2]),
    .o_stall_cnt(scnt_s), .o_flush_cnt(fcnt_s));

  function automatic logic [15:0] scnt(input int k);
    if (k == 0) return scnt_f;
    if (k == 1) return scnt_i;
    return {14'd0, scnt_s};
  endfunction

  function automatic logic [15:0] fcnt(input int k);
    if (k == 0) return fcnt_f;
    if (k == 1) return fcnt_i;
    return {14'd0, fcnt_s};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what each pipe stage holds, as whole instructions.
  typedef struct {
    bit v;
    int rd;
    int rs1;
    int rs2;
    bit rw;
    bit mr;
  } ins_t;

  ins_t pipe_m [3][3];            // [instance][0=EX, 1=MEM, 2=WB]
  int   scnt_m [3];
  int   fcnt_m [3];
  bit   fwd_en_m [3] = '{1'b1, 1'b0, 1'b1};
  int   cap_m [3]    = '{65535, 65535, 3};

  function automatic ins_t bubble();
    ins_t b;
    b.v = 0; b.rd = 0; b.rs1 = 0; b.rs2 = 0; b.rw = 0; b.mr = 0;
    return b;
  endfunction

  function automatic bit writes(input ins_t m);
    return m.v && m.rw && (m.rd != 0);
  endfunction

  // Newest producer of a nonzero source wins; the register file otherwise.
  function automatic int fwd_code(input ins_t mem, input ins_t wb, input int src, input bit en);
    if (!en || src == 0) return 0;
    if (writes(mem) && mem.rd == src) return 2;
    if (writes(wb) && wb.rd == src) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin : cmp
      ins_t nw;
      bit   r1, r2, haz, stall;
      int   depth;
      if (rst) begin
        chk($sformatf("rst_pc_en%0d", k), pc_en[k], 0);
        chk($sformatf("rst_ifid_en%0d", k), ifid_en[k], 0);
        chk($sformatf("rst_ifid_flush%0d", k), ifid_flush[k], 1);
        chk($sformatf("rst_idex_flush%0d", k), idex_flush[k], 1);
        chk($sformatf("rst_fwd_a%0d", k), fwd_a[k], 0);
        chk($sformatf("rst_fwd_b%0d", k), fwd_b[k], 0);
        chk($sformatf("rst_byp_a%0d", k), byp_a[k], 0);
        chk($sformatf("rst_byp_b%0d", k), byp_b[k], 0);
        for (int a = 0; a < 3; a++) pipe_m[k][a] = bubble();
        scnt_m[k] = 0;
        fcnt_m[k] = 0;
      end else begin
        r1 = u1 && (rs1 != 0);
        r2 = u2 && (rs2 != 0);
        haz = 0;
        depth = fwd_en_m[k] ? 1 : 2;
        for (int a = 0; a < depth; a++)
          if (writes(pipe_m[k][a]) && (!fwd_en_m[k] || pipe_m[k][a].mr) &&
              ((r1 && pipe_m[k][a].rd == int'(rs1)) || (r2 && pipe_m[k][a].rd == int'(rs2))))
            haz = 1;
        stall = id_valid && !br && haz;
        chk($sformatf("pc_en%0d", k), pc_en[k], !stall);
        chk($sformatf("ifid_en%0d", k), ifid_en[k], !stall);
        chk($sformatf("ifid_flush%0d", k), ifid_flush[k], br);
        chk($sformatf("idex_flush%0d", k), idex_flush[k], br || stall);
        chk($sformatf("fwd_a%0d", k), fwd_a[k],
            fwd_code(pipe_m[k][1], pipe_m[k][2], pipe_m[k][0].rs1, fwd_en_m[k]));
        chk($sformatf("fwd_b%0d", k), fwd_b[k],
            fwd_code(pipe_m[k][1], pipe_m[k][2], pipe_m[k][0].rs2, fwd_en_m[k]));
        chk($sformatf("byp_a%0d", k), byp_a[k],
            r1 && writes(pipe_m[k][2]) && pipe_m[k][2].rd == int'(rs1));
        chk($sformatf("byp_b%0d", k), byp_b[k],
            r2 && writes(pipe_m[k][2]) && pipe_m[k][2].rd == int'(rs2));
        chk($sformatf("stall_cnt%0d", k), scnt(k), scnt_m[k]);
        chk($sformatf("flush_cnt%0d", k), fcnt(k), fcnt_m[k]);
        if (stall && scnt_m[k] < cap_m[k]) scnt_m[k]++;
        if (br && fcnt_m[k] < cap_m[k]) fcnt_m[k]++;
        nw.v = id_valid; nw.rd = rd; nw.rw = rw; nw.mr = mr;
        nw.rs1 = u1 ? int'(rs1) : 0;
        nw.rs2 = u2 ? int'(rs2) : 0;
        pipe_m[k][2] = pipe_m[k][1];
        pipe_m[k][1] = pipe_m[k][0];
        pipe_m[k][0] = (br || stall) ? bubble() : nw;
      end
    end
  end

  task automatic issue(input bit r, input bit v, input int a1, input bit e1, input int a2,
                       input bit e2, input int d, input bit w, input bit m, input bit b);
    @(posedge clk);
    #1;
    rst = r; id_valid = v; rs1 = a1[4:0]; u1 = e1; rs2 = a2[4:0]; u2 = e2;
    rd = d[4:0]; rw = w; mr = m; br = b;
    @(negedge clk);
  endtask

  task automatic nop();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alu(input int d, input int a1, input int a2);
    issue(0, 1, a1, 1, a2, 1, d, 1, 0, 0);
  endtask

  task automatic ld(input int d, input int a1);
    issue(0, 1, a1, 1, 0, 0, d, 1, 1, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) nop();
  endtask

  initial begin
    rst = 1; id_valid = 0; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; rd = 0; rw = 0; mr = 0; br = 0;
    issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_rst_pc_en", pc_en[0], 0);
    chk("lit_rst_ifid_flush", ifid_flush[0], 1);
    chk("lit_rst_idex_flush", idex_flush[1], 1);
    nop();
    chk("lit_post_rst_stall_cnt", scnt(0), 0);
    chk("lit_post_rst_pc_en", pc_en[0], 1);

    // add x3,x1,x2 ; sub x4,x3,x5 ; and x9,x3,x6
    alu(3, 1, 2);
    alu(4, 3, 5);
    alu(9, 3, 6);
    chk("lit_t1_fwd_exmem", fwd_a[0], 2'b10);
    nop();
    chk("lit_t1_fwd_memwb", fwd_a[0], 2'b01);
    chk("lit_t1_stall_cnt", scnt(0), 0);
    drain();

    // lw x6,0(x1) ; add x7,x6,x2 (held one cycle in ID)
    ld(6, 1);
    alu(7, 6, 2);
    chk("lit_t2_pc_en", pc_en[0], 0);
    chk("lit_t2_ifid_en", ifid_en[0], 0);
    chk("lit_t2_idex_flush", idex_flush[0], 1);
    alu(7, 6, 2);
    chk("lit_t2_resume", pc_en[0], 1);
    chk("lit_t2_stall_cnt", scnt(0), 1);
    nop();
    chk("lit_t2_fwd_load", fwd_a[0], 2'b01);
    drain();

    // Interlock: add x3,x1,x2 ; or x8,x3,x3
    issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop();
    alu(3, 1, 2);
    alu(8, 3, 3);
    chk("lit_t3_stall1", pc_en[1], 0);
    alu(8, 3, 3);
    chk("lit_t3_stall2", pc_en[1], 0);
    alu(8, 3, 3);
    chk("lit_t3_release", pc_en[1], 1);
    chk("lit_t3_byp_a", byp_a[1], 1);
    chk("lit_t3_byp_b", byp_b[1], 1);
    chk("lit_t3_stall_cnt", scnt(1), 2);
    drain();

    // Branch taken together with a load-use hazard
    ld(6, 1);
    issue(0, 1, 6, 1, 2, 1, 7, 1, 0, 1);
    chk("lit_t4_ifid_flush", ifid_flush[0], 1);
    chk("lit_t4_idex_flush", idex_flush[0], 1);
    chk("lit_t4_pc_en", pc_en[0], 1);
    chk("lit_t4_ifid_en", ifid_en[0], 1);
    nop();
    chk("lit_t4_flush_cnt", fcnt(0), 1);
    chk("lit_t4_stall_cnt", scnt(0), 0);
    drain();

    // addi x0,x1,5 followed by readers of x0
    issue(0, 1, 1, 1, 0, 0, 0, 1, 0, 0);
    alu(10, 0, 0);
    chk("lit_t5_no_stall", pc_en[1], 1);
    alu(11, 0, 0);
    chk("lit_t5_no_stall2", pc_en[1], 1);
    chk("lit_t5_fwd", fwd_a[0], 2'b00);
    alu(12, 0, 0);
    chk("lit_t5_byp_a", byp_a[0], 0);
    chk("lit_t5_byp_b", byp_b[0], 0);
    drain();

    // Five load-use pairs: 2-bit counter saturates, 16-bit counter keeps going
    for (int i = 0; i < 5; i++) begin
      ld(6, 1);
      alu(7, 6, 2);
      alu(7, 6, 2);
    end
    nop();
    chk("lit_t6_sat", scnt(2), 3);
    chk("lit_t6_nosat", scnt(0), 5);

    // Reset lands in the middle of a load-use stall
    ld(6, 1);
    issue(1, 1, 6, 1, 2, 1, 7, 1, 0, 0);
    chk("lit_t6_rst_pc_en", pc_en[2], 0);
    chk("lit_t6_rst_ifid_flush", ifid_flush[2], 1);
    alu(7, 6, 2);
    chk("lit_t6_after_rst_pc_en", pc_en[2], 1);
    chk("lit_t6_after_rst_cnt", scnt(2), 0);
    drain();

    for (int n = 0; n < 3000; n++) begin
      issue($urandom_range(0, 99) < 2, $urandom_range(0, 7) != 0,
            $urandom_range(0, 3), $urandom_range(0, 1) != 0,
            $urandom_range(0, 3), $urandom_range(0, 1) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 99) < 8);
    end

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
